// File: rtl/pulse_pkg.sv
// pulse_pkg: shared definitions for the pulse-train generator.
//   state_e    : FSM state encoding (IDLE / HIGH / LOW)
//   clamp_len  : maps a phase length of 0 to 1 so every phase lasts >= 1 cycle
package pulse_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_e;

   function automatic logic [31:0] clamp_len(input logic [31:0] len);
      return (len == 32'd0) ? 32'd1 : len;
   endfunction

endpackage

// File: rtl/pulse_phase_counter.sv
// pulse_phase_counter: loadable down-counter timing one HIGH or LOW phase.
//   clk_i, rst_i : clock, async active-high reset
//   load_i       : load load_val_i (wins over en_i)
//   en_i         : decrement by one
//   cnt_o        : current count
//   zero_o       : count is zero (last cycle of the phase)
module pulse_phase_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)       cnt_q <= '0;
      else if (load_i) cnt_q <= load_val_i;
      else if (en_i)   cnt_q <= cnt_q - CNT_W'(1);
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: burst / continuous pulse-train generator.
//   clock, reset : system clock, async active-high reset
//   start, stop  : burst request (IDLE only) / abort (stop wins)
//   continuous   : repeat until stop, num_pulses ignored
//   high_len, low_len, num_pulses : burst shape, latched at start
//   signal       : registered pulse train
//   busy         : high while in HIGH or LOW
//   done         : one-cycle strobe after a normally completed burst
module pulse_train_gen
   import pulse_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int NUM_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             continuous,
   input  logic [CNT_W-1:0] high_len,
   input  logic [CNT_W-1:0] low_len,
   input  logic [NUM_W-1:0] num_pulses,
   output logic             signal,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   logic [NUM_W-1:0] pulses_left_q, pulses_left_d, pl_dec;
   logic             cont_q;
   logic [CNT_W-1:0] high_q, low_q;
   logic             cfg_ld;
   logic             signal_q, signal_d, busy_q, busy_d, done_q, done_d;

   logic             cnt_load, cnt_en, cnt_zero;
   logic [CNT_W-1:0] cnt_val, cnt_unused;

   // Reload values are "clamped length - 1": the phase ends on the cycle
   // the counter reads zero.
   logic [CNT_W-1:0] hi_in_m1, hi_q_m1, lo_q_m1;
   assign hi_in_m1 = CNT_W'(clamp_len(32'(high_len)) - 32'd1);
   assign hi_q_m1  = CNT_W'(clamp_len(32'(high_q))   - 32'd1);
   assign lo_q_m1  = CNT_W'(clamp_len(32'(low_q))    - 32'd1);
   assign pl_dec   = pulses_left_q - NUM_W'(1);

   pulse_phase_counter #(.CNT_W(CNT_W)) u_phase (
      .clk_i      (clock),
      .rst_i      (reset),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .en_i       (cnt_en),
      .cnt_o      (cnt_unused),
      .zero_o     (cnt_zero)
   );

   // State, configuration and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         pulses_left_q <= '0;
         cont_q        <= 1'b0;
         high_q        <= '0;
         low_q         <= '0;
         signal_q      <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         pulses_left_q <= pulses_left_d;
         if (cfg_ld) begin
            cont_q <= continuous;
            high_q <= high_len;
            low_q  <= low_len;
         end
         signal_q <= signal_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d       = state_q;
      pulses_left_d = pulses_left_q;
      cfg_ld        = 1'b0;
      cnt_load      = 1'b0;
      cnt_val       = '0;
      done_d        = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               if (continuous || num_pulses != '0) begin
                  state_d       = ST_HIGH;
                  cfg_ld        = 1'b1;
                  cnt_load      = 1'b1;
                  cnt_val       = hi_in_m1;
                  pulses_left_d = num_pulses;
               end else begin
                  done_d = 1'b1;   // empty burst completes at once
               end
            end
         end
         ST_HIGH: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (cnt_zero) begin
               state_d  = ST_LOW;
               cnt_load = 1'b1;
               cnt_val  = lo_q_m1;
            end
         end
         ST_LOW: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (cnt_zero) begin
               if (!cont_q) pulses_left_d = pl_dec;
               if (cont_q || pl_dec != '0) begin
                  state_d  = ST_HIGH;
                  cnt_load = 1'b1;
                  cnt_val  = hi_q_m1;
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic: registered versions of the next state
   always_comb begin
      signal_d = (state_d == ST_HIGH);
      busy_d   = (state_d != ST_IDLE);
      cnt_en   = (state_q != ST_IDLE) && !cnt_zero;
   end

   assign signal = signal_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
module tb_pulse_train_gen;
   localparam int CW = 4;
   localparam int NW = 4;

   logic          clock = 1'b0;
   logic          reset, start, stop, continuous;
   logic [CW-1:0] high_len, low_len;
   logic [NW-1:0] num_pulses;
   logic          signal, busy, done;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clock = ~clock;

   pulse_train_gen #(.CNT_W(CW), .NUM_W(NW)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .continuous (continuous),
      .high_len   (high_len),
      .low_len    (low_len),
      .num_pulses (num_pulses),
      .signal     (signal),
      .busy       (busy),
      .done       (done)
   );

   task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
   endtask

   task automatic chk3(input string tag, input int cyc, input logic s, input logic b, input logic d);
      chk({tag, "_signal"}, cyc, 32'(signal), 32'(s));
      chk({tag, "_busy"},   cyc, 32'(busy),   32'(b));
      chk({tag, "_done"},   cyc, 32'(done),   32'(d));
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   function automatic logic exp_sig(input int c, input int hh, input int ll);
      return ((c - 1) % (hh + ll)) < hh;
   endfunction

   // Drive config with start for one edge; returns in cycle 1 of the burst.
   task automatic launch(input int h, input int l, input int n, input logic c);
      high_len   = CW'(h);
      low_len    = CW'(l);
      num_pulses = NW'(n);
      continuous = c;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   // Checks a whole non-continuous burst from cycle 1 through the done strobe.
   task automatic verify(input string tag, input int h, input int l, input int n);
      int hh, ll, t;
      hh = (h == 0) ? 1 : h;
      ll = (l == 0) ? 1 : l;
      t  = n * (hh + ll);
      for (int c = 1; c <= t; c++) begin
         chk3(tag, c, exp_sig(c, hh, ll), 1'b1, 1'b0);
         tick();
      end
      chk3(tag, t + 1, 1'b0, 1'b0, 1'b1);
      tick();
      chk3(tag, t + 2, 1'b0, 1'b0, 1'b0);
      tick();
      chk3(tag, t + 3, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
      high_len = '0; low_len = '0; num_pulses = '0;
      #2;
      chk3("reset", 0, 1'b0, 1'b0, 1'b0);
      tick();
      chk3("reset_edge", 0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      tick();
      chk3("idle", 0, 1'b0, 1'b0, 1'b0);

      // 1: 3 pulses of 6/6
      launch(6, 6, 3, 1'b0);
      verify("t1", 6, 6, 3);

      // 2: zero high length clamps to 1; then an empty burst
      launch(0, 1, 4, 1'b0);
      verify("t2", 0, 1, 4);
      launch(5, 5, 0, 1'b0);
      chk3("t2_empty", 1, 1'b0, 1'b0, 1'b1);
      tick();
      chk3("t2_empty", 2, 1'b0, 1'b0, 1'b0);

      // 3: continuous abort in second high phase; start+stop in IDLE ignored
      launch(3, 2, 0, 1'b1);
      for (int c = 1; c <= 6; c++) begin
         chk3("t3", c, exp_sig(c, 3, 2), 1'b1, 1'b0);
         tick();
      end
      chk3("t3", 7, 1'b1, 1'b1, 1'b0);
      stop = 1'b1;
      tick();
      chk3("t3_stop", 8, 1'b0, 1'b0, 1'b0);
      stop = 1'b0;
      tick();
      chk3("t3_stop", 9, 1'b0, 1'b0, 1'b0);
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      chk3("t3_ss", 1, 1'b0, 1'b0, 1'b0);
      tick();
      chk3("t3_ss", 2, 1'b0, 1'b0, 1'b0);
      continuous = 1'b0;

      // 4: async reset during LOW, then a short burst
      launch(4, 4, 2, 1'b0);
      for (int c = 1; c <= 5; c++) tick();
      chk3("t4_low", 6, 1'b0, 1'b1, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk3("t4_rst", 6, 1'b0, 1'b0, 1'b0);
      #2;
      reset = 1'b0;
      tick();
      chk3("t4_idle", 7, 1'b0, 1'b0, 1'b0);
      launch(2, 2, 1, 1'b0);
      verify("t4", 2, 2, 1);

      // 5: inputs changed while busy are ignored; back-to-back from done cycle
      launch(3, 2, 2, 1'b0);
      for (int c = 1; c <= 10; c++) begin
         if (c == 2) begin high_len = CW'(7); start = 1'b1; end
         if (c == 3) start = 1'b0;
         chk3("t5", c, exp_sig(c, 3, 2), 1'b1, 1'b0);
         tick();
      end
      chk3("t5_done", 11, 1'b0, 1'b0, 1'b1);
      high_len = CW'(1); low_len = CW'(1); num_pulses = NW'(1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk3("t5_b2b", 1, 1'b1, 1'b1, 1'b0);
      tick();
      chk3("t5_b2b", 2, 1'b0, 1'b1, 1'b0);
      tick();
      chk3("t5_b2b", 3, 1'b0, 1'b0, 1'b1);
      tick();
      chk3("t5_b2b", 4, 1'b0, 1'b0, 1'b0);

      // 6: maximum widths, 15 pulses of 15/15 (450 busy cycles)
      launch(15, 15, 15, 1'b0);
      verify("t6", 15, 15, 15);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
- Synthesizable, parametrised pulse-train generator clocked by the system clock.
- Produces a burst of N pulses. Each pulse is high for a programmable number of cycles and low for a programmable number of cycles.
- Bursts can also run in continuous mode until stopped.
- Replaces delay-based testbench pulse generation. Used both as a stimulus source in sequential-circuit benches and as an on-chip strobe source.

Parameters:
- CNT_W, 8: width of the high/low phase-length inputs and of the phase counter.
- NUM_W, 4: width of the pulse-count input and of the remaining-pulse counter.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a burst; sampled on posedge, acted on only in IDLE.
- stop  in  1  abort the burst in progress; sampled on posedge.
- continuous  in  1  1 = repeat pulses until stop, ignoring num_pulses; latched at start.
- high_len  in  CNT_W  cycles high per pulse; latched at start.
- low_len  in  CNT_W  cycles low per pulse; latched at start.
- num_pulses  in  NUM_W  pulses per burst; latched at start.
- signal  out  1  registered pulse-train output.
- busy  out  1  high while in HIGH or LOW state.
- done  out  1  one-cycle strobe when a burst completes normally.

Behaviour:
- Reset (asynchronous, active-high), while reset is high:
  - state = IDLE.
  - signal = 0, busy = 0, done = 0.
  - All counters and latched configuration = 0.
- States: IDLE, HIGH, LOW. All outputs are registered, with no combinational path from inputs to outputs.
- Length clamping: high_len = 0 and low_len = 0 are each treated as 1, so a phase always lasts at least 1 cycle. Lengths are at most 2^CNT_W - 1 cycles.
- IDLE, start = 1, stop = 0, num_pulses != 0 or continuous = 1, at edge E0:
  - Latch the configuration.
  - Go to HIGH with signal = 1 and busy = 1.
  - Load phase_cnt = high_len - 1 and pulses_left = num_pulses.
- IDLE, start = 1, num_pulses = 0, continuous = 0:
  - No pulse is generated.
  - done = 1 for the next cycle only; busy stays 0.
- HIGH:
  - phase_cnt decrements each edge.
  - At the edge where phase_cnt == 0: go to LOW, signal = 0, phase_cnt = low_len - 1.
  - Net effect: signal is high for exactly high_len cycles.
- LOW:
  - phase_cnt decrements each edge.
  - At the edge where phase_cnt == 0, pulses_left is decremented (non-continuous only) and then:
    - If continuous = 1, or the decremented pulses_left != 0: go to HIGH, signal = 1, phase_cnt = high_len - 1.
    - Otherwise: go to IDLE, busy = 0, done = 1 for one cycle.
- Latency and duration:
  - signal rises in the first cycle after the start edge.
  - busy lasts exactly num_pulses × (high_len + low_len) cycles.
  - done is asserted in the cycle immediately after the last busy cycle.
- stop, in HIGH or LOW:
  - At the next edge: go to IDLE, signal = 0, busy = 0.
  - done stays 0; the partial pulse is truncated.
- stop has priority over start in the same cycle; in IDLE, stop alone has no effect.
- start while busy is ignored. Input changes while busy are ignored because the configuration is latched.
- start in the same cycle that done is high (IDLE) is accepted, giving back-to-back bursts with one low cycle between them.
- Continuous mode: pulses_left is not decremented; the burst runs until stop or reset.
- Reset asserted mid-burst: immediate return to the reset values, with no done.
- No arithmetic overflow is possible: counters only count down and are reloaded from latched inputs.

Decomposition:
- Shared package pulse_pkg:
  - State encoding constants ST_IDLE = 2'd0, ST_HIGH = 2'd1, ST_LOW = 2'd2.
  - The helper that clamps a 0 length to 1.
- One natural sub-module, pulse_phase_counter: a loadable CNT_W down-counter with load and enable inputs and a zero flag, instantiated once for phase timing.
- The FSM and pulses_left counter stay in pulse_train_gen.

Test Plan:
1. Burst: high_len = 6, low_len = 6, num_pulses = 3, continuous = 0, start pulse at edge E0 -> three pulses, each high 6 cycles / low 6 cycles, starting in cycle 1; busy high for 36 cycles; done = 1 in cycle 37 only.
2. Minimum and zero lengths: high_len = 0, low_len = 1, num_pulses = 4 -> alternating 1-cycle high / 1-cycle low for 8 cycles, then done; separately, num_pulses = 0 -> no signal edge, done in cycle 1, busy never set.
3. Abort: continuous = 1, high_len = 3, low_len = 2, assert stop during the second high phase -> signal = 0 and busy = 0 at the next edge, done never asserted; start together with stop in IDLE is ignored.
4. Reset mid-burst: assert reset asynchronously between edges during a LOW phase -> signal, busy and done go to 0 immediately; after release, a new start with high_len = 2, low_len = 2, num_pulses = 1 gives 2 high, 2 low, then done.
5. Back-to-back and ignored inputs: change high_len and pulse start while busy -> the burst timing is unchanged; start in the done cycle -> a new burst with signal high exactly 1 cycle after done.
6. Maximum width: CNT_W = 4, high_len = 15, low_len = 15, num_pulses = 2^NUM_W - 1 = 15 -> 15 pulses of 15/15 cycles, busy = 450 cycles, done once.
